uart_byte_receiver: RTL

- Byte-level UART receiver: deserialises the async serial line into 8-bit bytes.
- Sits directly upstream of the memory-word decoder and drives its byteFromRx / rxByteReady / new_rx_byte_indicate inputs.
- Format fixed at 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Mid-bit sampling, with a 2-flop synchroniser on the line.

---
 rtl/uart_byte_receiver_pkg.sv | 14 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_byte_receiver.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_byte_receiver_pkg.sv
// Shared UART definitions: receiver state encoding and the default
// baud divisor, kept here so the future transmitter uses the same rate.
package uart_byte_receiver_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rxState_t;

   localparam int ClksPerBitDefault = 434;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input plus falling-edge
// detect on the synchronised level; all stages reset to the idle-high value.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic fallEdge
);

   logic rxS1;
   logic rxS2;
   logic rxPrev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rxS1   <= 1'b1;
         rxS2   <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxS1   <= din;
         rxS2   <= rxS1;
         rxPrev <= rxS2;
      end
   end

   assign level    = rxS2;
   assign fallEdge = rxPrev & ~rxS2;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver with mid-bit sampling; feeds the memory-word
// decoder through byteFromRx / rxByteReady / new_rx_byte_indicate.
module uart_byte_receiver
   import uart_byte_receiver_pkg::*;
#(
   parameter int clks_per_bit = ClksPerBitDefault
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] byteFromRx,
   output logic       rxByteReady,
   output logic       new_rx_byte_indicate,
   output logic       rxFrameError
);

   localparam int cnt_width = $clog2(clks_per_bit);
   localparam logic [cnt_width-1:0] HalfLast = cnt_width'(clks_per_bit / 2 - 1);
   localparam logic [cnt_width-1:0] BitLast  = cnt_width'(clks_per_bit - 1);

   rxState_t             state;
   rxState_t             stateNext;
   logic [cnt_width-1:0] counter;
   logic [cnt_width-1:0] counterNext;
   logic [2:0]           bitIdx;
   logic [2:0]           bitIdxNext;
   logic [7:0]           shiftReg;
   logic [7:0]           shiftNext;
   logic [7:0]           byteNext;
   logic                 errNext;
   logic                 indNext;
   logic                 rxLevel;
   logic                 rxFall;

   uart_rx_sync uSync (
      .clk      (clk),
      .rst      (rst),
      .din      (rx),
      .level    (rxLevel),
      .fallEdge (rxFall)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state                <= IDLE;
         counter              <= '0;
         bitIdx               <= '0;
         shiftReg             <= '0;
         byteFromRx           <= '0;
         rxFrameError         <= 1'b0;
         new_rx_byte_indicate <= 1'b0;
      end else begin
         state                <= stateNext;
         counter              <= counterNext;
         bitIdx               <= bitIdxNext;
         shiftReg             <= shiftNext;
         byteFromRx           <= byteNext;
         rxFrameError         <= errNext;
         new_rx_byte_indicate <= indNext;
      end
   end

   always_comb begin
      stateNext   = state;
      counterNext = counter;
      bitIdxNext  = bitIdx;
      shiftNext   = shiftReg;
      byteNext    = byteFromRx;
      errNext     = rxFrameError;
      indNext     = 1'b0;
      unique case (state)
         IDLE: begin
            // Edge-triggered so a held-low line (break) starts only one frame
            if (rxFall) begin
               stateNext   = START;
               counterNext = '0;
            end
         end
         START: begin
            if (counter == HalfLast) begin
               counterNext = '0;
               if (!rxLevel) begin
                  indNext    = 1'b1;
                  bitIdxNext = '0;
                  stateNext  = DATA;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               counterNext = counter + 1'b1;
            end
         end
         DATA: begin
            if (counter == BitLast) begin
               counterNext = '0;
               shiftNext   = {rxLevel, shiftReg[7:1]};
               bitIdxNext  = bitIdx + 1'b1;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end
            end else begin
               counterNext = counter + 1'b1;
            end
         end
         STOP: begin
            if (counter == BitLast) begin
               counterNext = '0;
               byteNext    = shiftReg;
               errNext     = ~rxLevel;
               stateNext   = IDLE;
            end else begin
               counterNext = counter + 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign rxByteReady = (state == IDLE);

endmodule
